// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding types and constants for the instruction encoder.
// Format codes match the in_fmt encoding on the encoder boundary.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed immediate into its RV32I bit positions for the given
// format and flags immediates that cannot be represented (or bad formats).
module imm_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_illegal
);

    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    // A value fits in N signed bits when every bit from N-1 upward is a copy of the sign.
    assign w_fits12 = (&i_imm[31:11]) || !(|i_imm[31:11]);
    assign w_fits13 = (&i_imm[31:12]) || !(|i_imm[31:12]);
    assign w_fits21 = (&i_imm[31:20]) || !(|i_imm[31:20]);

    always_comb begin
        o_imm_bits = '0;
        o_illegal  = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_imm_bits = '0;
            end
            FMT_I: begin
                o_imm_bits = {i_imm[11:0], 20'd0};
                o_illegal  = !w_fits12;
            end
            FMT_S: begin
                o_imm_bits = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
                o_illegal  = !w_fits12;
            end
            FMT_B: begin
                o_imm_bits = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
                o_illegal  = !w_fits13 || i_imm[0];
            end
            FMT_U: begin
                o_imm_bits = {i_imm[31:12], 12'd0};
                o_illegal  = |i_imm[11:0];
            end
            FMT_J: begin
                o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
                o_illegal  = !w_fits21 || i_imm[0];
            end
            default: begin
                o_illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: packs decoded fields into 32-bit words
// and tags each with a wrapping instruction-memory write address.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter int          MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam int OFF_W = $clog2(MEM_BYTES);

    logic [31:0]      w_imm_bits;
    logic             w_illegal;
    logic [31:0]      w_fields;
    logic [31:0]      w_enc;
    logic             w_accept;
    logic             w_s1_adv;
    logic             w_xfer;

    logic             r_s1_valid;
    logic [31:0]      r_s1_instr;
    logic             r_s1_err;
    logic             r_s2_valid;
    logic [31:0]      r_s2_instr;
    logic             r_s2_err;
    logic [OFF_W-1:0] r_offset;
    logic [7:0]       r_err_count;

    imm_pack u_imm_pack (
        .i_fmt      (in_fmt),
        .i_imm      (in_imm),
        .o_imm_bits (w_imm_bits),
        .o_illegal  (w_illegal)
    );

    always_comb begin
        w_fields = {25'd0, in_opcode};
        case (in_fmt)
            FMT_R:        w_fields = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:        w_fields = {12'd0, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S, FMT_B: w_fields = {7'd0, in_rs2, in_rs1, in_funct3, 5'd0, in_opcode};
            FMT_U, FMT_J: w_fields = {20'd0, in_rd, in_opcode};
            default:      w_fields = {25'd0, in_opcode};
        endcase
    end

    assign w_enc = w_illegal ? NOP : (w_fields | w_imm_bits);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload stable until that edge.
    // in_ready depends only on stage occupancy and out_ready, never on in_valid.
    assign w_xfer   = r_s2_valid && out_ready;
    assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_instr  <= '0;
            r_s1_err    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_instr  <= '0;
            r_s2_err    <= 1'b0;
            r_offset    <= '0;
            r_err_count <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_instr <= w_enc;
                r_s1_err   <= w_illegal;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_instr <= r_s1_instr;
                r_s2_err   <= r_s1_err;
            end else if (w_xfer) begin
                r_s2_valid <= 1'b0;
            end

            // Offset width equals log2(MEM_BYTES), so the add wraps on its own.
            if (w_xfer) begin
                r_offset <= r_offset + OFF_W'(4);
                if (r_s2_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign out_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_offset);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, range errors,
// backpressure, address wrap and reset-while-stalled.
module tb_instr_encoder;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b1;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    logic        wr_in_ready;
    logic        wr_out_valid;
    logic [31:0] wr_out_instr;
    logic [31:0] wr_out_addr;
    logic        wr_out_err;
    logic [7:0]  wr_err_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] wrap_off = 32'h0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_instr;
    logic [31:0] hold_addr;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    instr_encoder #(.BASE_ADDR(32'h0000_1000), .MEM_BYTES(8)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (wr_in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (wr_out_valid),
        .out_ready (out_ready),
        .out_instr (wr_out_instr),
        .out_addr  (wr_out_addr),
        .out_err   (wr_out_err),
        .err_count (wr_err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every transfer is compared against the oldest accepted request.
    always @(negedge clk) begin
        if (rst) begin
            hold_v   = 1'b0;
            exp_q.delete();
            exp_addr = 32'h0;
            wrap_off = 32'h0;
        end else begin
            if (hold_v) begin
                check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
                check_eq("stall_instr", out_instr, hold_instr);
                check_eq("stall_addr", out_addr, hold_addr);
            end
            hold_v     = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_addr  = out_addr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stray_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check_eq("instr", out_instr, e[31:0]);
                    check_eq("err", {31'd0, out_err}, {31'd0, e[32]});
                    check_eq("addr", out_addr, exp_addr);
                    check_eq("wrap_instr", wr_out_instr, e[31:0]);
                    check_eq("wrap_err", {31'd0, wr_out_err}, {31'd0, e[32]});
                    check_eq("wrap_addr", wr_out_addr, 32'h0000_1000 + wrap_off);
                end
                exp_addr = (exp_addr + 32'd4) % 32'd4096;
                wrap_off = (wrap_off + 32'd4) % 32'd8;
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        logic acc;
        int   budget;
        budget    = 0;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        acc       = 1'b0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (acc) exp_q.push_back({exp_err, exp_instr});
        else check_eq("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        check_eq("rst_out_addr", out_addr, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_wrap_addr", wr_out_addr, 32'h0000_1000);
        check_eq("rst_wrap_ready", {31'd0, wr_in_ready}, 32'd1);
        check_eq("rst_wrap_errcnt", {24'd0, wr_err_count}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        do_reset();
        check_reset_values();

        // First word and its two-cycle latency.
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        idle();
        @(negedge clk);
        check_eq("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_cycle2", {31'd0, out_valid}, 32'd1);
        check_eq("first_addr", out_addr, 32'd0);
        @(posedge clk);
        #1;
        wait_drain();

        // Legal encodings back to back, including range boundaries.
        send(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0);
        send(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(FMT_U, OP_LUI,    5'd5, 5'd31, 5'd0, 3'd7, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(FMT_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0);
        send(FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0);
        send(FMT_R, 7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      32'h7FF0_0093, 1'b0);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,      32'h7E00_0FE3, 1'b0);
        send(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
        idle();
        wait_drain();
        check_eq("no_err_yet", {24'd0, err_count}, 32'd0);

        // Range and format errors become NOPs.
        send(FMT_I, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      NOP, 1'b1);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         NOP, 1'b1);
        send(FMT_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, NOP, 1'b1);
        send(3'd7,  OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         NOP, 1'b1);
        idle();
        wait_drain();
        check_eq("err_count_4", {24'd0, err_count}, 32'd4);

        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      NOP, 1'b1);
        send(FMT_J, OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,   NOP, 1'b1);
        send(FMT_S, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF, NOP, 1'b1);
        idle();
        wait_drain();
        check_eq("err_count_7", {24'd0, err_count}, 32'd7);

        for (int i = 0; i < 248; i++) begin
            send(3'd6, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 1'b1);
        end
        idle();
        wait_drain();
        check_eq("err_count_255", {24'd0, err_count}, 32'd255);
        for (int i = 0; i < 45; i++) begin
            send(3'd6, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 1'b1);
        end
        idle();
        wait_drain();
        check_eq("err_count_sat", {24'd0, err_count}, 32'd255);

        // Backpressure: two words fill both stages, then in_ready must drop.
        out_ready = 1'b0;
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
        idle();
        @(negedge clk);
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        fork
            begin
                send(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0);
                send(FMT_I, OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0213, 1'b0);
                send(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0293, 1'b0);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while stalled discards in-flight words.
        out_ready = 1'b0;
        send(FMT_I, OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0060_0313, 1'b0);
        send(FMT_I, OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0393, 1'b0);
        idle();
        @(posedge clk);
        #1;
        do_reset();
        check_reset_values();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Address wrap on the 8-byte instance: BASE, BASE+4, BASE.
        send(FMT_U, OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_10B7, 1'b0);
        send(FMT_U, OP_LUI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000, 32'h0000_2137, 1'b0);
        send(FMT_U, OP_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000, 32'h0000_31B7, 1'b0);
        idle();
        wait_drain();
        check_eq("wrap_next_addr", wr_out_addr, 32'h0000_1004);
        check_eq("main_next_addr", out_addr, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
